// File: rtl/decode_byte_queue_prefix_if.sv
// Fetch-line and decode-window signals between the fetch unit, the byte queue
// and the control-store lookup stage.
interface decode_byte_queue_prefix_if;
    logic         fetch_valid;
    logic [127:0] fetch_line;
    logic         fetch_ready;
    logic         flush;
    logic [3:0]   flush_off;
    logic         dec_valid;
    logic         dec_ready;
    logic [3:0]   dec_len;
    logic         isREP;
    logic         isSIZE;
    logic         isSEG;
    logic [5:0]   segSEL;
    logic [3:0]   prefSize;
    logic [7:0]   B1;
    logic [7:0]   B2;
    logic [7:0]   B3;
    logic [127:0] win;

    modport master (
        output fetch_valid, fetch_line, flush, flush_off, dec_ready, dec_len,
        input  fetch_ready, dec_valid, isREP, isSIZE, isSEG, segSEL, prefSize,
               B1, B2, B3, win
    );

    modport slave (
        input  fetch_valid, fetch_line, flush, flush_off, dec_ready, dec_len,
        output fetch_ready, dec_valid, isREP, isSIZE, isSEG, segSEL, prefSize,
               B1, B2, B3, win
    );
endinterface

// File: rtl/decode_byte_queue_prefix.sv
// Decode front end: circular byte queue fed by fetch lines, with legacy-prefix
// parsing and opcode-byte extraction at the queue head.
module decode_byte_queue_prefix #(
    parameter int LINE_BYTES = 16,
    parameter int Q_BYTES    = 32,
    parameter int MAX_PREF   = 4
) (
    input logic                       clk,
    input logic                       reset,
    decode_byte_queue_prefix_if.slave bus
);
    localparam int PTR_W = $clog2(Q_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_BYTES);

    logic [7:0]       mem_q [Q_BYTES];
    logic [7:0]       mem_d [Q_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       skip_q, skip_d;
    logic             skipPend_q, skipPend_d;

    logic             accept;
    logic             consume;
    logic [PTR_W-1:0] tail;
    logic [7:0]       winByte [LINE_BYTES];

    assign bus.fetch_ready = (count_q <= LINE_CNT) && !bus.flush;
    assign bus.dec_valid   = (count_q >= LINE_CNT) && !bus.flush;
    assign accept          = bus.fetch_valid && bus.fetch_ready;
    assign consume         = bus.dec_valid && bus.dec_ready;
    assign tail            = head_q + count_q[PTR_W-1:0];

    // A skip-pending accept always follows a flush, so the queue is empty and
    // no consume can coincide with it.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        mem_d      = mem_q;
        head_d     = head_q;
        count_d    = count_q;
        skip_d     = skip_q;
        skipPend_d = skipPend_q;
        if (bus.flush) begin
            head_d     = '0;
            count_d    = '0;
            skip_d     = bus.flush_off;
            skipPend_d = 1'b1;
        end else begin
            if (accept) begin
                for (int i = 0; i < LINE_BYTES; i++) begin
                    idx        = tail + PTR_W'(i);
                    mem_d[idx] = bus.fetch_line[8*i +: 8];
                end
            end
            if (accept && skipPend_q) begin
                head_d     = PTR_W'(skip_q);
                count_d    = LINE_CNT - CNT_W'(skip_q);
                skipPend_d = 1'b0;
            end else begin
                count_d = count_q + (accept ? LINE_CNT : '0)
                                  - (consume ? CNT_W'(bus.dec_len) : '0);
                head_d  = head_q + (consume ? PTR_W'(bus.dec_len) : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Q_BYTES; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            count_q    <= '0;
            skip_q     <= '0;
            skipPend_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            count_q    <= count_d;
            skip_q     <= skip_d;
            skipPend_q <= skipPend_d;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            idx        = head_q + PTR_W'(i);
            winByte[i] = mem_q[idx];
        end
    end

    always_comb begin
        bus.win = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            bus.win[8*i +: 8] = winByte[i];
        end
    end

    // Segment overrides overwrite segSEL, so the last one scanned wins.
    always_comb begin
        logic       scanning;
        logic       isPref;
        logic [3:0] prefCnt;
        scanning     = 1'b1;
        isPref       = 1'b0;
        prefCnt      = '0;
        bus.isREP    = 1'b0;
        bus.isSIZE   = 1'b0;
        bus.isSEG    = 1'b0;
        bus.segSEL   = '0;
        for (int i = 0; i < MAX_PREF; i++) begin
            if (scanning) begin
                isPref = 1'b1;
                case (winByte[i])
                    8'h66:        bus.isSIZE = 1'b1;
                    8'hF2, 8'hF3: bus.isREP  = 1'b1;
                    8'h26: begin bus.isSEG = 1'b1; bus.segSEL = 6'b000001; end
                    8'h2E: begin bus.isSEG = 1'b1; bus.segSEL = 6'b000010; end
                    8'h36: begin bus.isSEG = 1'b1; bus.segSEL = 6'b000100; end
                    8'h3E: begin bus.isSEG = 1'b1; bus.segSEL = 6'b001000; end
                    8'h64: begin bus.isSEG = 1'b1; bus.segSEL = 6'b010000; end
                    8'h65: begin bus.isSEG = 1'b1; bus.segSEL = 6'b100000; end
                    default:      isPref = 1'b0;
                endcase
                if (isPref) begin
                    prefCnt = prefCnt + 4'd1;
                end else begin
                    scanning = 1'b0;
                end
            end
        end
        bus.prefSize = prefCnt;
        bus.B1       = winByte[prefCnt];
        bus.B2       = winByte[prefCnt + 4'd1];
        bus.B3       = winByte[prefCnt + 4'd2];
    end
endmodule

// File: tb/tb_decode_byte_queue_prefix.sv
// Bench for the decode byte queue: directed scenarios plus random traffic,
// checked every cycle against a byte-queue model of the instruction stream.
module tb_decode_byte_queue_prefix;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_byte_queue_prefix_if bus();

    decode_byte_queue_prefix dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic         rep;
        logic         size;
        logic         seg;
        logic [5:0]   sel;
        logic [3:0]   ps;
        logic [7:0]   b1;
        logic [7:0]   b2;
        logic [7:0]   b3;
        logic [127:0] win;
    } parse_t;

    logic [7:0] mq[$];
    bit         mSkipPend = 1'b0;
    logic [3:0] mSkip     = '0;
    int         vectors     = 0;
    int         miscompares = 0;

    function automatic logic [5:0] segOf(logic [7:0] b);
        case (b)
            8'h26:   return 6'b000001;
            8'h2E:   return 6'b000010;
            8'h36:   return 6'b000100;
            8'h3E:   return 6'b001000;
            8'h64:   return 6'b010000;
            8'h65:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic bit isPrefix(logic [7:0] b);
        return (b == 8'h66) || (b == 8'hF2) || (b == 8'hF3) || (segOf(b) != 6'b0);
    endfunction

    // Count the leading prefix run first, then derive every flag from that run.
    function automatic parse_t modelParse();
        parse_t p;
        int     n;
        p = '0;
        for (int i = 0; i < 16; i++) p.win[8*i +: 8] = mq[i];
        n = 0;
        while (n < 4 && isPrefix(mq[n])) n++;
        for (int i = 0; i < n; i++) begin
            if (mq[i] == 8'h66) p.size = 1'b1;
            if (mq[i] == 8'hF2 || mq[i] == 8'hF3) p.rep = 1'b1;
            if (segOf(mq[i]) != 6'b0) begin
                p.seg = 1'b1;
                p.sel = segOf(mq[i]);
            end
        end
        p.ps = 4'(n);
        p.b1 = mq[n];
        p.b2 = mq[n + 1];
        p.b3 = mq[n + 2];
        return p;
    endfunction

    task automatic checkVal(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(bit rst, bit fv, logic [127:0] line, bit fl,
                                 logic [3:0] foff, bit dr, logic [3:0] dlen);
        reset           = rst;
        bus.fetch_valid = fv;
        bus.fetch_line  = line;
        bus.flush       = fl;
        bus.flush_off   = foff;
        bus.dec_ready   = dr;
        bus.dec_len     = dlen;
        #1;
    endtask

    task automatic checkOutput();
        bit     expFR;
        bit     expDV;
        parse_t p;
        expFR = (mq.size() <= 16) && !bus.flush;
        expDV = (mq.size() >= 16) && !bus.flush;
        checkVal("fetch_ready", bus.fetch_ready, expFR);
        checkVal("dec_valid", bus.dec_valid, expDV);
        if (expDV) begin
            p = modelParse();
            checkVal("isREP", bus.isREP, p.rep);
            checkVal("isSIZE", bus.isSIZE, p.size);
            checkVal("isSEG", bus.isSEG, p.seg);
            checkVal("segSEL", bus.segSEL, p.sel);
            checkVal("prefSize", bus.prefSize, p.ps);
            checkVal("B1", bus.B1, p.b1);
            checkVal("B2", bus.B2, p.b2);
            checkVal("B3", bus.B3, p.b3);
            checkVal("win", bus.win, p.win);
        end
        if (bus.dec_valid && bus.dec_ready) begin
            checkVal("len_legal",
                     (bus.dec_len != 4'd0) && (bus.dec_len > bus.prefSize), 1'b1);
        end
    endtask

    task automatic updateModel();
        bit accept;
        bit consume;
        int start;
        if (reset) begin
            mq.delete();
            mSkipPend = 1'b0;
        end else if (bus.flush) begin
            mq.delete();
            mSkipPend = 1'b1;
            mSkip     = bus.flush_off;
        end else begin
            accept  = bus.fetch_valid && (mq.size() <= 16);
            consume = bus.dec_ready && (mq.size() >= 16);
            if (consume) repeat (int'(bus.dec_len)) void'(mq.pop_front());
            if (accept) begin
                start = mSkipPend ? int'(mSkip) : 0;
                for (int i = start; i < 16; i++) mq.push_back(bus.fetch_line[8*i +: 8]);
                mSkipPend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        checkOutput();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    function automatic logic [127:0] seqLine(logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    function automatic logic [7:0] randByte();
        logic [7:0] pref [9];
        pref = '{8'h66, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
        if ($urandom_range(9, 0) < 4) return pref[$urandom_range(8, 0)];
        return 8'($urandom);
    endfunction

    function automatic logic [127:0] randLine();
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = randByte();
        return l;
    endfunction

    initial begin
        logic [127:0] l;
        parse_t       p;
        bit           rst, fl, fv, dr;
        logic [3:0]   foff, dlen;

        reset           = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_line  = '0;
        bus.flush       = 1'b0;
        bus.flush_off   = '0;
        bus.dec_ready   = 1'b0;
        bus.dec_len     = 4'd1;
        @(posedge clk);
        @(negedge clk);

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
            checkVal("t1_dec_valid", bus.dec_valid, 1'b0);
            checkVal("t1_fetch_ready", bus.fetch_ready, 1'b1);
            checkVal("t1_prefSize", bus.prefSize, 4'd0);
            tick();
        end

        // 66 F3 2E prefixes, then consume five bytes
        l = '0;
        l[7:0] = 8'h66; l[15:8] = 8'hF3; l[23:16] = 8'h2E;
        l[31:24] = 8'h01; l[39:32] = 8'hC8;
        applyStimulus(0, 1, l, 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd5);
        checkVal("t2_dec_valid", bus.dec_valid, 1'b1);
        checkVal("t2_isSIZE", bus.isSIZE, 1'b1);
        checkVal("t2_isREP", bus.isREP, 1'b1);
        checkVal("t2_isSEG", bus.isSEG, 1'b1);
        checkVal("t2_segSEL", bus.segSEL, 6'b000010);
        checkVal("t2_prefSize", bus.prefSize, 4'd3);
        checkVal("t2_B1", bus.B1, 8'h01);
        checkVal("t2_B2", bus.B2, 8'hC8);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t2_after_dec_valid", bus.dec_valid, 1'b0);
        checkVal("t2_after_fetch_ready", bus.fetch_ready, 1'b1);
        tick();

        // Fill to 32 bytes, then a line offered during consume is refused
        applyStimulus(1, 0, '0, 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'h10), 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'h50), 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'hA0), 0, 0, 1, 4'd3);
        checkVal("t3_full_fetch_ready", bus.fetch_ready, 1'b0);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t3_29_fetch_ready", bus.fetch_ready, 1'b0);
        checkVal("t3_29_dec_valid", bus.dec_valid, 1'b1);
        checkVal("t3_29_win0", bus.win[7:0], 8'h13);
        tick();

        // Tail wraps to byte 0 while consuming from head 16
        applyStimulus(1, 0, '0, 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'h80), 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'hA0), 0, 0, 1, 4'd15);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd1);
        tick();
        applyStimulus(0, 1, seqLine(8'hC0), 0, 0, 1, 4'd6);
        checkVal("t4_head16_win0", bus.win[7:0], 8'hA0);
        checkVal("t4_head16_fetch_ready", bus.fetch_ready, 1'b1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd10);
        checkVal("t4_wrap_win0", bus.win[7:0], 8'hA6);
        checkVal("t4_wrap_fetch_ready", bus.fetch_ready, 1'b0);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t4_new_win0", bus.win[7:0], 8'hC0);
        checkVal("t4_new_win15", bus.win[127:120], 8'hCF);
        tick();

        // Flush with a skip offset of 6
        applyStimulus(0, 1, seqLine(8'h00), 1, 4'd6, 0, 4'd1);
        checkVal("t5_flush_fetch_ready", bus.fetch_ready, 1'b0);
        checkVal("t5_flush_dec_valid", bus.dec_valid, 1'b0);
        tick();
        applyStimulus(0, 1, seqLine(8'h00), 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t5_skip_dec_valid", bus.dec_valid, 1'b0);
        checkVal("t5_skip_fetch_ready", bus.fetch_ready, 1'b1);
        tick();
        applyStimulus(0, 1, seqLine(8'h90), 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t5_dec_valid", bus.dec_valid, 1'b1);
        checkVal("t5_win0", bus.win[7:0], 8'h06);
        tick();

        // Four segment prefixes, the fifth prefix byte becomes B1
        applyStimulus(1, 0, '0, 0, 0, 0, 4'd1);
        tick();
        l = '0;
        l[7:0] = 8'h26; l[15:8] = 8'h64; l[23:16] = 8'h3E;
        l[31:24] = 8'h65; l[39:32] = 8'h2E; l[47:40] = 8'h90;
        applyStimulus(0, 1, l, 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t6_prefSize", bus.prefSize, 4'd4);
        checkVal("t6_segSEL", bus.segSEL, 6'b100000);
        checkVal("t6_B1", bus.B1, 8'h2E);
        checkVal("t6_B2", bus.B2, 8'h90);
        tick();
        applyStimulus(1, 0, '0, 0, 0, 0, 4'd1);
        tick();
        applyStimulus(0, 0, '0, 0, 0, 0, 4'd1);
        checkVal("t6_reset_dec_valid", bus.dec_valid, 1'b0);
        checkVal("t6_reset_fetch_ready", bus.fetch_ready, 1'b1);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(199, 0) == 0);
            fl   = ($urandom_range(39, 0) == 0);
            foff = 4'($urandom);
            fv   = ($urandom_range(9, 0) < 7);
            dr   = ($urandom_range(9, 0) < 6);
            if (mq.size() >= 16) begin
                p    = modelParse();
                dlen = 4'($urandom_range(15, int'(p.ps) + 1));
            end else begin
                dlen = 4'($urandom_range(15, 1));
            end
            applyStimulus(rst, fv, randLine(), fl, foff, dr, dlen);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
